if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register.
//  - Owns the PC and runs a req/ack handshake to instruction memory with wait states.
//  - Presents {instr_out, PC_out, instr_valid} for IF/ID to latch on cycles with stall=0.
//  - Applies branch/jump/exception redirects and discards in-flight wrong-path fetches.

---
 rtl/if_fetch_unit_if.sv | 11 +
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: request/ack handshake with wait states.
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding IF/ID: PC ownership, imem handshake, 1-entry skid, redirect/kill.
// Optional macro FETCH_PERF_EN adds saturating perf_fetch_cnt / perf_kill_cnt outputs.
module if_fetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h300
) (
    input  logic               clk,
    input  logic               rst_n,
    if_fetch_unit_if.master    imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [29:0]        redirect_pc,
    output logic [31:0]        instr_out,
    output logic [29:0]        PC_out,
    output logic               instr_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_kill_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] KILL = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [29:0] kaddr_q, kaddr_d;
    logic [31:0] instr_q, instr_d;
    logic [29:0] pco_q, pco_d;
    logic        vld_q, vld_d;
    logic        skv_q, skv_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [29:0] skid_pc_q, skid_pc_d;
    logic        req;
    logic        acc;

    assign req            = (state_q == REQ) || (state_q == KILL);
    assign acc            = req && imem.imem_ack;
    assign imem.imem_req  = req;
    // KILL keeps the abandoned address on the bus; pc already holds the redirect target.
    assign imem.imem_addr = (state_q == KILL) ? kaddr_q : pc_q;
    assign instr_out      = instr_q;
    assign PC_out         = pco_q;
    assign instr_valid    = vld_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kaddr_d      = kaddr_q;
        instr_d      = instr_q;
        pco_d        = pco_q;
        vld_d        = vld_q;
        skv_d        = skv_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            skv_d   = 1'b0;
            instr_d = 32'd0;
            pco_d   = RESET_PC;
            vld_d   = 1'b0;
            // An outstanding request must still complete, so wait it out in KILL.
            if (req && !acc) begin
                state_d = KILL;
                if (state_q == REQ) kaddr_d = pc_q;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem.imem_ack) begin
                        pc_d = pc_q + 30'd1;
                        if (vld_q && stall) begin
                            skid_instr_d = imem.imem_rdata;
                            skid_pc_d    = pc_q;
                            skv_d        = 1'b1;
                            state_d      = HOLD;
                        end else begin
                            instr_d = imem.imem_rdata;
                            pco_d   = pc_q;
                            vld_d   = 1'b1;
                        end
                    end else if (!stall) begin
                        vld_d   = 1'b0;
                        instr_d = 32'd0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d = skid_instr_q;
                        pco_d   = skid_pc_q;
                        vld_d   = 1'b1;
                        skv_d   = 1'b0;
                        state_d = REQ;
                    end
                end
                KILL: if (imem.imem_ack) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pco_q   <= RESET_PC;
            vld_q   <= 1'b0;
            skv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            vld_q   <= vld_d;
            skv_q   <= skv_d;
        end
    end

    // Skid payload and kill address are only read when their qualifying state says so.
    always_ff @(posedge clk) begin
        kaddr_q      <= kaddr_d;
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

`ifdef FETCH_PERF_EN
    logic        fetch_ev;
    logic        kill_ev;
    logic [31:0] fetch_cnt_q;
    logic [31:0] kill_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    assign fetch_ev = !redirect && (state_q == REQ) && imem.imem_ack;
    assign kill_ev  = acc && (redirect || (state_q == KILL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= sat_inc(fetch_cnt_q, fetch_ev);
            kill_cnt_q  <= sat_inc(kill_cnt_q, kill_ev);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic against a queue-based fetch model.
module tb_if_fetch_unit;
    localparam logic [29:0] RESET_PC = 30'h300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic [31:0] instr_out;
    logic [29:0] PC_out;
    logic        instr_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_out   (instr_out),
        .PC_out      (PC_out),
        .instr_valid (instr_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model: mq holds delivered-but-not-consumed words; mq[0] is what sits on the outputs.
    typedef struct packed { logic [31:0] instr; logic [29:0] pc; } ent_t;
    ent_t        mq[$];
    logic [29:0] m_pc, m_daddr, m_pcout;
    bit          m_started, m_disc;
    logic [31:0] m_fetch, m_kill;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b11} ^ 32'hC0DE_5A00;
    endfunction

    function automatic bit m_req();
        return m_started && (m_disc || mq.size() < 2);
    endfunction

    function automatic logic [29:0] m_addr();
        return m_disc ? m_daddr : m_pc;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC; m_daddr = RESET_PC; m_pcout = RESET_PC;
        m_started = 0; m_disc = 0; m_fetch = 0; m_kill = 0;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [29:0] rpc,
                              input bit ak, input logic [31:0] rdat);
        bit rq, acc;
        rq  = m_req();
        acc = rq && ak;
        if (rd) begin
            if (acc) m_kill++;
            if (rq && !acc) begin
                if (!m_disc) m_daddr = m_pc;
                m_disc = 1;
            end else begin
                m_disc = 0;
            end
            m_pc = rpc;
            mq.delete();
            m_pcout = RESET_PC;
            m_started = 1;
        end else if (!m_started) begin
            m_started = 1;
        end else begin
            if (m_disc) begin
                if (acc) begin m_disc = 0; m_kill++; end
            end else begin
                if (!st && mq.size() > 0) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back('{instr: rdat, pc: m_pc});
                    m_pc = m_pc + 30'd1;
                    m_fetch++;
                end
            end
            if (mq.size() > 0) m_pcout = mq[0].pc;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req()});
        if (m_req()) check("imem_addr", {2'd0, bus.imem_addr}, {2'd0, m_addr()});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, (mq.size() > 0)});
        check("instr_out", instr_out, (mq.size() > 0) ? mq[0].instr : 32'd0);
        check("PC_out", {2'd0, PC_out}, {2'd0, m_pcout});
`ifdef FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        check("perf_kill_cnt", perf_kill_cnt, m_kill);
`endif
    endtask

    // Drive one cycle's inputs, let the edge happen, then compare on the falling edge.
    task automatic cycle(input bit st, input bit rd, input logic [29:0] rpc, input bit ak);
        logic [31:0] rdat;
        rdat = ak ? mem_word(m_addr()) : $urandom();
        stall = st; redirect = rd; redirect_pc = rpc;
        bus.imem_ack = ak; bus.imem_rdata = rdat;
        @(posedge clk);
        model_step(st, rd, rpc, ak, rdat);
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        stall = 0; redirect = 0; bus.imem_ack = 0;
        check_all();
        rst_n = 1'b1;
        #1 check_all();
    endtask

    initial begin
        int w;
        bit rq, ak, st, rd;
        logic [29:0] rpc;
        rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = '0;
        bus.imem_ack = 0; bus.imem_rdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        #1 check_all();

        // Zero-wait memory, no stall: one instruction per cycle from 0x300.
        for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);

        // Two wait cycles per request.
        w = 0;
        for (int i = 0; i < 15; i++) begin
            rq = m_req();
            ak = rq && (w == 2);
            cycle(0, 0, '0, ak);
            if (rq) w = ak ? 0 : w + 1;
        end

        // Stall while valid with an ack: skid, HOLD (ack ignored), release.
        cycle(0, 0, '0, 1);
        cycle(1, 0, '0, 1);
        cycle(1, 0, '0, 1);
        cycle(1, 0, '0, 0);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);

        // Redirect to 0x1000 while the request at 0x305 is waiting.
        reset_mid();
        for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 0);
        cycle(0, 1, 30'h1000, 0);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);

        // Redirect to the top word, wrap to 0; redirect under stall still flushes.
        cycle(0, 1, 30'h3FFF_FFFF, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
        cycle(1, 0, '0, 1);
        cycle(1, 1, 30'h3FFF_FFFE, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

        // Reset in the middle of a wait; fetch restarts at 0x300.
        cycle(0, 0, '0, 0);
        reset_mid();
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            ak  = ($urandom_range(0, 1) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFF - 30'($urandom_range(0, 2))
                                              : 30'($urandom());
            if (rd && m_disc) ak = 0;
            cycle(st, rd, rpc, ak);
            if ($urandom_range(0, 499) == 0) reset_mid();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
